conv_window_stream: RTL and testbench
=====================================

Name: conv_window_stream

Overview:
- Parametrised successor to the single-channel convolution slice buffer.
- Accepts one K-tall column per cycle for CH channels over a valid/ready stream.
- Holds the last K columns per channel and presents a full KxK window per channel, with configurable horizontal stride, row-end flush and output back-pressure.
- Sits between the line/slice fetcher and the MAC array.

Parameters:
- DW, 12, data element width in bits
- K, 5, window height and width
- CH, 1, independent channels, each with its own window
- S, 1, horizontal stride in columns (1..K)
- IDXW, 8, width of the window-index counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  column present on in_data
- in_ready  out  1  block can accept a column this cycle
- in_data  in  CH*K*DW  column; channel c, row r at bits [(c*K+r)*DW +: DW]
- in_last  in  1  qualifies the accepted column as the last of a row
- out_valid  out  1  window on out_data is valid
- out_ready  in  1  consumer takes the window
- out_data  out  CH*K*K*DW  window; channel c, column j (0 = oldest), row r at [((c*K+j)*K+r)*DW +: DW]
- out_idx  out  IDXW  index of the presented window within the current row (0-based)

Behaviour:
- Reset (rst_n low, asynchronous):
  - all window registers = 0
  - fill = 0, scnt = 0, out_idx = 0
  - out_valid = 0
  - in_ready = 1 once reset is released
- Handshakes:
  - in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready.
  - Output handshake = out_valid && out_ready. While out_valid && !out_ready, out_data and out_idx are held stable and no column is accepted.
- On accept, every channel shifts: column j takes column j+1, and the new column enters column K-1 (newest). The oldest column is dropped.
- fill:
  - saturating count of columns in the current row, 0..K.
  - fill_next = min(fill+1, K).
- Emit decision (evaluated on accept, registered):
  - If fill_next == K and fill < K (first full window of the row): emit, scnt = 0.
  - Else if fill == K: if scnt == S-1, emit and scnt = 0; otherwise scnt += 1.
  - An emit sets out_valid on the next cycle, so latency is 1 cycle from the accepting edge.
- out_valid clears on an output handshake unless the same edge also produces an emit.
- out_idx:
  - 0 on the first window of a row.
  - increments on each emit after the first; wraps modulo 2^IDXW.
- in_last on an accepted column:
  - The emit decision for that column is applied normally.
  - fill, scnt and the next-window index are then reset to 0, so the next row starts clean.
  - Window registers are not cleared, so a window emitted by the last column stays intact until consumed.
  - A row shorter than K columns produces no window.
- S > K is illegal: flag it with an elaboration-time $error. S = 1 means every column after fill produces a window.
- Simultaneous events:
  - Output handshake and accept on the same edge is legal; the old window is consumed and the shifted window is what follows.
  - Reset mid-row drops any pending window.
- Channels are fully lockstep. There is no per-channel valid.

Decomposition:
- Shared package conv_pkg:
  - default DW, K, CH, S
  - localparam COL_W = K*DW
  - localparam WIN_W = K*K*DW
  - index helper functions for the in_data and out_data layouts
- One sub-module, conv_column_shift: per-channel K-column shift register with a shift enable, exposing its KxK window. It is instantiated CH times.
- Control logic (fill, scnt, out_valid, out_idx) lives in the top block.

Test Plan:
- Basic fill (DW=12, K=5, CH=1, S=1): after reset, push columns {0,1,2,3,4}, {10..14}, ..., {40..44} with out_ready=1.
  - out_valid rises 1 cycle after the 5th accept, with out_idx=0.
  - Column 0 holds rows 00..04; column 4 holds 40..44.
  - A 6th column {50..54} gives a window of columns 10..54 with out_idx=1.
- Stride (S=2): push 9 columns.
  - Windows appear after the 5th, 7th and 9th accepts, with out_idx 0, 1, 2.
  - No out_valid after the 6th or 8th accept.
- Back-pressure: hold out_ready=0 after the first window.
  - in_ready=0, and out_data/out_idx are stable for 10 cycles.
  - Raise out_ready together with in_valid: the window is consumed, the new column is accepted on the same edge, and the next window appears 1 cycle later.
- Row end:
  - A 7-column row with in_last on the 7th yields windows idx 0, 1, 2.
  - The next row's first 4 columns yield nothing; its 5th yields idx=0.
  - A 3-column row with in_last yields no window.
- Multi-channel (CH=2): ch0 columns 0x0nr, ch1 columns 0x8nr. Both windows appear in the same cycle, and each occupies its own out_data slice.
- Async reset: assert rst_n=0 mid-row between clock edges.
  - out_valid drops immediately, and out_data = 0.
  - After release, a window needs 5 fresh columns.

Source files
------------

// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared defaults and bit-layout helpers for the streaming convolution window.
//   in_data  : channel c, row r             at in_lsb(c, r, K, DW)
//   out_data : channel c, column j, row r   at out_lsb(c, j, r, K, DW)
//              (column 0 is the oldest column of the window)
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int DW_DEF = 12;
    localparam int K_DEF  = 5;
    localparam int CH_DEF = 1;
    localparam int S_DEF  = 1;

    localparam int COL_W = K_DEF * DW_DEF;
    localparam int WIN_W = K_DEF * K_DEF * DW_DEF;

    // LSB of one element of an input column bundle.
    function automatic int in_lsb(input int c, input int r, input int k, input int dw);
        return (c * k + r) * dw;
    endfunction

    // LSB of one element of an output window bundle.
    function automatic int out_lsb(input int c, input int j, input int r,
                                   input int k, input int dw);
        return ((c * k + j) * k + r) * dw;
    endfunction

endpackage

// File: rtl/conv_window_stream_shift.sv
// -----------------------------------------------------------------------------
// conv_column_shift
// One channel's K-column shift register. On shift, column j takes column j+1
// and col enters column K-1 (newest); column 0 (oldest) is dropped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   shift      : advance the window by one column
//   col        : incoming K-tall column, row r at [r*DW +: DW]
//   win        : KxK window, column j row r at [(j*K+r)*DW +: DW]
// -----------------------------------------------------------------------------
module conv_column_shift
    import conv_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int K  = K_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic [K*DW-1:0]   col,
    output logic [K*K*DW-1:0] win
);

    // NOTE: the window registers are reset on purpose: a cleared window is
    // visible on out_data after reset, so this storage is not left uninitialised.
    if (K == 1) begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     win <= '0;
            else if (shift) win <= col;
        end
    end else begin : g_multi
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its neighbour.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     win <= '0;
            else if (shift) win <= {col, win[K*K*DW-1:K*DW]};
        end
    end

endmodule

// File: rtl/conv_window_stream.sv
// -----------------------------------------------------------------------------
// conv_window_stream
// Accepts one K-tall column per cycle for CH lockstep channels and presents a
// KxK window per channel every S columns once K columns of a row are held.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : column stream handshake
//   in_data             : CH columns, channel c row r at [(c*K+r)*DW +: DW]
//   in_last             : accepted column is the last one of its row
//   out_valid/out_ready : window stream handshake
//   out_data            : CH windows, [((c*K+j)*K+r)*DW +: DW], j=0 oldest
//   out_idx             : 0-based index of the window within its row
// -----------------------------------------------------------------------------
module conv_window_stream
    import conv_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int K    = K_DEF,
    parameter int CH   = CH_DEF,
    parameter int S    = S_DEF,
    parameter int IDXW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CH*K*DW-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*K*K*DW-1:0] out_data,
    output logic [IDXW-1:0]      out_idx
);

    localparam int             FW        = $clog2(K + 1);
    localparam logic [FW-1:0]  FILL_MAX  = FW'(K);
    localparam logic [FW-1:0]  SCNT_LAST = FW'(S - 1);

    if (S < 1 || S > K) begin : g_bad_stride
        $error("conv_window_stream: stride S=%0d must lie in 1..K (K=%0d)", S, K);
    end

    logic [FW-1:0]   fill;
    logic [FW-1:0]   fill_next;
    logic [FW-1:0]   scnt;
    logic [IDXW-1:0] next_idx;
    logic            accept;
    logic            out_fire;
    logic            first_full;
    logic            emit;

    // A held window blocks new columns, which keeps out_data stable.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // NOTE: every signal here is assigned on every pass, so no latch is inferred.
    always_comb begin
        fill_next  = (fill == FILL_MAX) ? fill : fill + FW'(1);
        first_full = (fill_next == FILL_MAX) && (fill != FILL_MAX);
        emit       = accept && (first_full || (fill == FILL_MAX && scnt == SCNT_LAST));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= '0;
            scnt      <= '0;
            next_idx  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
        end else begin
            // A fresh emit wins over consumption of the previous window.
            if (emit)          out_valid <= 1'b1;
            else if (out_fire) out_valid <= 1'b0;

            if (emit) begin
                out_idx  <= first_full ? '0 : next_idx;
                next_idx <= first_full ? IDXW'(1) : next_idx + IDXW'(1);
            end

            if (accept) begin
                if (in_last) begin
                    // Row end: the emit above still stands, then counters restart.
                    fill     <= '0;
                    scnt     <= '0;
                    next_idx <= '0;
                end else begin
                    fill <= fill_next;
                    if (first_full)
                        scnt <= '0;
                    else if (fill == FILL_MAX)
                        scnt <= (scnt == SCNT_LAST) ? '0 : scnt + FW'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        conv_column_shift #(
            .DW (DW),
            .K  (K)
        ) u_shift (
            .clk   (clk),
            .rst_n (rst_n),
            .shift (accept),
            .col   (in_data[in_lsb(c, 0, K, DW) +: K*DW]),
            .win   (out_data[out_lsb(c, 0, 0, K, DW) +: K*K*DW])
        );
    end

endmodule

// File: tb/tb_conv_window_stream.sv
// -----------------------------------------------------------------------------
// tb_conv_window_stream
// Two instances of conv_window_stream (both DW=12, K=5, CH=2):
//   d=0 : S=1, IDXW=8
//   d=1 : S=2, IDXW=3
// A reference model keeps the full column history and row position and derives
// each window from "column p of a row emits when p>=K and (p-K)%S==0".
// -----------------------------------------------------------------------------
module tb_conv_window_stream;

    localparam int DW = 12;
    localparam int K  = 5;
    localparam int CH = 2;
    localparam int CW = CH * K * DW;
    localparam int WW = CH * K * K * DW;
    localparam int HN = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid  [2];
    logic            in_ready  [2];
    logic [CW-1:0]   in_data   [2];
    logic            in_last   [2];
    logic            out_valid [2];
    logic            out_ready [2];
    logic [WW-1:0]   out_data  [2];
    logic [7:0]      out_idx0;
    logic [2:0]      out_idx1;

    // reference model state
    logic [CW-1:0]   hist [2][HN];
    int              hn        [2];
    int              row_pos   [2];
    bit              exp_valid [2];
    int              exp_idx   [2];
    logic [WW-1:0]   exp_win   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_window_stream #(.DW(DW), .K(K), .CH(CH), .S(1), .IDXW(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_idx(out_idx0)
    );

    conv_window_stream #(.DW(DW), .K(K), .CH(CH), .S(2), .IDXW(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_idx(out_idx1)
    );

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] idx_of(input int d);
        return (d == 0) ? out_idx0 : {5'd0, out_idx1};
    endfunction

    // ch0 row r = n*16+r, ch1 row r = 0x800+n*16+r
    function automatic logic [CW-1:0] col_pat(input int n);
        logic [CW-1:0] v = '0;
        for (int r = 0; r < K; r++) begin
            v[r*DW +: DW]       = DW'(n * 16 + r);
            v[(K + r)*DW +: DW] = DW'(12'h800 + n * 16 + r);
        end
        return v;
    endfunction

    function automatic logic [CW-1:0] col_rand();
        logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
        return v[CW-1:0];
    endfunction

    // window = last K accepted columns, oldest first, regrouped per channel
    function automatic logic [WW-1:0] build_window(input int d);
        logic [WW-1:0] w = '0;
        logic [CW-1:0] colv;
        for (int j = 0; j < K; j++) begin
            colv = hist[d][(hn[d] - K + j) % HN];
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < K; r++)
                    w[((c*K + j)*K + r)*DW +: DW] = colv[(c*K + r)*DW +: DW];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            row_pos[d]   = 0;
        end
    endtask

    // One clock cycle on instance d; called just after a falling edge.
    task automatic step(input int d, input bit v, input logic [CW-1:0] data,
                        input bit last, input bit ordy);
        bit acc, hs;
        int sv, iw, p;
        sv = (d == 0) ? 1 : 2;
        iw = (d == 0) ? 8 : 3;
        in_valid[d]  = v;
        in_data[d]   = data;
        in_last[d]   = last;
        out_ready[d] = ordy;
        #1;
        check($sformatf("in_ready[%0d]", d), WW'(in_ready[d]), WW'(!exp_valid[d] || ordy));
        hs  = exp_valid[d] && ordy;
        acc = v && (!exp_valid[d] || ordy);
        @(posedge clk);
        if (hs) exp_valid[d] = 1'b0;
        if (acc) begin
            hist[d][hn[d] % HN] = data;
            hn[d]++;
            row_pos[d]++;
            p = row_pos[d];
            if (p >= K && (p - K) % sv == 0) begin
                exp_valid[d] = 1'b1;
                exp_idx[d]   = ((p - K) / sv) % (1 << iw);
                exp_win[d]   = build_window(d);
            end
            if (last) row_pos[d] = 0;
        end
        @(negedge clk);
        in_valid[d]  = 1'b0;
        in_last[d]   = 1'b0;
        out_ready[d] = 1'b0;
        check($sformatf("out_valid[%0d]", d), WW'(out_valid[d]), WW'(exp_valid[d]));
        if (exp_valid[d]) begin
            check($sformatf("out_idx[%0d]", d), WW'(idx_of(d)), WW'(exp_idx[d]));
            check($sformatf("out_data[%0d]", d), out_data[d], exp_win[d]);
        end
    endtask

    // n columns with out_ready=1; counts windows seen
    task automatic run_row(input int d, input int n, input bit last_at_end,
                           input int base, output int wins);
        wins = 0;
        for (int i = 0; i < n; i++) begin
            step(d, 1'b1, col_pat(base + i), last_at_end && (i == n - 1), 1'b1);
            if (out_valid[d]) wins++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wins;
        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_data[d] = '0; in_last[d] = 1'b0; out_ready[d] = 1'b0;
            hn[d] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_valid[%0d]", d), WW'(out_valid[d]), '0);
            check($sformatf("rst_ready[%0d]", d), WW'(in_ready[d]), WW'(1));
            check($sformatf("rst_data[%0d]", d), out_data[d], '0);
            check($sformatf("rst_idx[%0d]", d), WW'(idx_of(d)), '0);
        end
        @(negedge clk);

        // basic fill, S=1
        for (int n = 0; n < 5; n++) step(0, 1'b1, col_pat(n), 1'b0, 1'b1);
        check("basic_idx0", WW'(out_idx0), '0);
        check("basic_c0j0r2", WW'(out_data[0][2*DW +: DW]), WW'(12'h002));
        check("basic_c0j4r4", WW'(out_data[0][24*DW +: DW]), WW'(12'h044));
        check("basic_c1j0r0", WW'(out_data[0][25*DW +: DW]), WW'(12'h800));
        step(0, 1'b1, col_pat(5), 1'b0, 1'b1);
        check("basic_idx1", WW'(out_idx0), WW'(1));
        check("basic_shift_j0", WW'(out_data[0][0 +: DW]), WW'(12'h010));

        // back-pressure: window from column 5 is pending, hold out_ready low
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, col_pat(6), 1'b0, 1'b0);
            check("bp_in_ready", WW'(in_ready[0]), '0);
        end
        step(0, 1'b1, col_pat(6), 1'b0, 1'b1);
        check("bp_release_idx", WW'(out_idx0), WW'(2));
        check("bp_release_valid", WW'(out_valid[0]), WW'(1));

        // row ends
        step(0, 1'b1, col_pat(7), 1'b1, 1'b1);
        run_row(0, 7, 1'b1, 20, wins);
        check("row7_wins", WW'(wins), WW'(3));
        run_row(0, 4, 1'b0, 40, wins);
        check("row_first4_wins", WW'(wins), '0);
        run_row(0, 1, 1'b1, 44, wins);
        check("row_5th_win", WW'(wins), WW'(1));
        check("row_5th_idx", WW'(out_idx0), '0);
        run_row(0, 3, 1'b1, 50, wins);
        check("row3_wins", WW'(wins), '0);

        // stride 2: windows after the 5th, 7th and 9th accepts
        for (int n = 1; n <= 9; n++) begin
            step(1, 1'b1, col_pat(n), n == 9, 1'b1);
            check($sformatf("stride_valid_%0d", n), WW'(out_valid[1]),
                  WW'(n == 5 || n == 7 || n == 9));
            if (n == 9) check("stride_idx_9", WW'(out_idx1), WW'(2));
        end

        // async reset mid-row with a window pending
        step(0, 1'b1, col_pat(60), 1'b1, 1'b1);
        for (int n = 0; n < 5; n++) step(0, 1'b1, col_pat(61 + n), 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", WW'(out_valid[0]), '0);
        check("arst_data", out_data[0], '0);
        check("arst_idx", WW'(out_idx0), '0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_row(0, 4, 1'b0, 70, wins);
        check("arst_first4_wins", WW'(wins), '0);
        run_row(0, 1, 1'b0, 74, wins);
        check("arst_5th_win", WW'(wins), WW'(1));

        // randomized traffic on both instances
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 600; i++)
                step(d, $urandom_range(0, 9) < 7, col_rand(),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);

        // index wrap: 262 columns at S=1/IDXW=8, 25 columns at S=2/IDXW=3
        step(0, 1'b1, col_rand(), 1'b1, 1'b1);
        run_row(0, 262, 1'b1, 0, wins);
        check("wrap8_wins", WW'(wins), WW'(258));
        check("wrap8_idx", WW'(out_idx0), WW'(1));
        step(1, 1'b1, col_rand(), 1'b1, 1'b1);
        run_row(1, 25, 1'b1, 100, wins);
        check("wrap3_wins", WW'(wins), WW'(11));
        check("wrap3_idx", WW'(out_idx1), WW'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
